// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle for the bimodal branch predictor.
// The master drives fetch PCs and resolutions; the slave returns predictions and redirects.
interface branch_predictor_if #(
  parameter int DATA_SIZE = 32
);
  logic                 i_fetch_valid;
  logic [DATA_SIZE-1:0] i_fetch_pc;
  logic                 i_res_valid;
  logic [DATA_SIZE-1:0] i_res_pc;
  logic                 i_res_taken;
  logic                 i_res_pred;
  logic [DATA_SIZE-1:0] i_res_target;
  logic                 o_ready;
  logic                 o_pred_valid;
  logic                 o_pred_taken;
  logic                 o_redirect;
  logic [DATA_SIZE-1:0] o_redirect_pc;

  modport master (
    output i_fetch_valid, i_fetch_pc, i_res_valid, i_res_pc, i_res_taken, i_res_pred, i_res_target,
    input  o_ready, o_pred_valid, o_pred_taken, o_redirect, o_redirect_pc
  );

  modport slave (
    input  i_fetch_valid, i_fetch_pc, i_res_valid, i_res_pc, i_res_taken, i_res_pred, i_res_target,
    output o_ready, o_pred_valid, o_pred_taken, o_redirect, o_redirect_pc
  );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal predictor: 2-bit saturating counters indexed by pc[IDX_W+1:2], 1-cycle prediction,
// mispredict redirect then FLUSH_CYCLES of ignored resolutions. BP_STATS_EN adds branch/mispredict counters.
module branch_predictor #(
  parameter int         DATA_SIZE    = 32,
  parameter int         BHT_ENTRIES  = 64,
  parameter int         FLUSH_CYCLES = 2,
  parameter logic [1:0] INIT_CTR     = 2'b01
) (
  input  logic              i_clk,
  input  logic              i_rst,
  branch_predictor_if.slave bp
`ifdef BP_STATS_EN
  ,
  output logic [31:0]       o_stat_branches,
  output logic [31:0]       o_stat_mispredicts
`endif
);
  localparam int IDX_W  = $clog2(BHT_ENTRIES);
  localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_FLUSH} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     init_idx_q, init_idx_d;
  logic [FCNT_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic                 ready_q, ready_d;
  logic [DATA_SIZE-1:0] redirect_pc_q, redirect_pc_d;
  logic                 pred_valid_q, pred_taken_q, redirect_q;
  logic [1:0]           bht_q [BHT_ENTRIES];

  logic [IDX_W-1:0]     fetch_idx, res_idx, bht_widx;
  logic [1:0]           res_ctr, res_ctr_nxt, bht_wdat;
  logic                 bht_we, accept, mispredict;
  logic                 unused_fetch_pc;

  assign fetch_idx       = bp.i_fetch_pc[IDX_W+1:2];
  assign res_idx         = bp.i_res_pc[IDX_W+1:2];
  assign unused_fetch_pc = ^bp.i_fetch_pc;
  assign res_ctr         = bht_q[res_idx];
  assign res_ctr_nxt     = bp.i_res_taken ? ((res_ctr == 2'd3) ? 2'd3 : res_ctr + 2'd1)
                                          : ((res_ctr == 2'd0) ? 2'd0 : res_ctr - 2'd1);

  always_comb begin
    state_d       = state_q;
    init_idx_d    = init_idx_q;
    flush_cnt_d   = flush_cnt_q;
    ready_d       = ready_q;
    redirect_pc_d = redirect_pc_q;
    accept        = 1'b0;
    mispredict    = 1'b0;
    bht_we        = 1'b0;
    bht_widx      = res_idx;
    bht_wdat      = res_ctr_nxt;
    case (state_q)
      S_INIT: begin
        bht_we   = 1'b1;
        bht_widx = init_idx_q;
        bht_wdat = INIT_CTR;
        if (init_idx_q == IDX_W'(BHT_ENTRIES - 1)) begin
          state_d = S_RUN;
          ready_d = 1'b1;
        end else begin
          init_idx_d = init_idx_q + 1'b1;
        end
      end
      S_RUN: begin
        if (bp.i_res_valid) begin
          accept = 1'b1;
          bht_we = 1'b1;
          if (bp.i_res_taken != bp.i_res_pred) begin
            mispredict    = 1'b1;
            state_d       = S_FLUSH;
            flush_cnt_d   = FCNT_W'(FLUSH_CYCLES);
            redirect_pc_d = bp.i_res_taken ? bp.i_res_target : bp.i_res_pc + DATA_SIZE'(4);
          end
        end
      end
      S_FLUSH: begin
        // Leaving on the count of 1 gives exactly FLUSH_CYCLES ignored cycles.
        flush_cnt_d = flush_cnt_q - 1'b1;
        if (flush_cnt_q == FCNT_W'(1)) state_d = S_RUN;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_INIT;
      init_idx_q    <= '0;
      flush_cnt_q   <= '0;
      ready_q       <= 1'b0;
      redirect_pc_q <= '0;
      redirect_q    <= 1'b0;
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_idx_q    <= init_idx_d;
      flush_cnt_q   <= flush_cnt_d;
      ready_q       <= ready_d;
      redirect_pc_q <= redirect_pc_d;
      redirect_q    <= mispredict;
      pred_valid_q  <= bp.i_fetch_valid;
      pred_taken_q  <= ready_q & bp.i_fetch_valid & bht_q[fetch_idx][1];
    end
  end

  // Table read above sees the pre-write value; no same-index bypass.
  always_ff @(posedge i_clk) begin
    if (!i_rst && bht_we) bht_q[bht_widx] <= bht_wdat;
  end

  assign bp.o_ready       = ready_q;
  assign bp.o_pred_valid  = pred_valid_q;
  assign bp.o_pred_taken  = pred_taken_q;
  assign bp.o_redirect    = redirect_q;
  assign bp.o_redirect_pc = redirect_pc_q;

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q, stat_mis_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      if (accept && stat_br_q != '1) stat_br_q <= stat_br_q + 32'd1;
      if (mispredict && stat_mis_q != '1) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign o_stat_branches    = stat_br_q;
  assign o_stat_mispredicts = stat_mis_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif
endmodule
